// File: rtl/mips_pkg.sv
// Shared MIPS encodings and pipeline-controller state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic logic [31:0] enc_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detection: EX-stage load whose destination feeds a source of the ID-stage instruction.
module hazard_detect
(
    input  logic       MemtoRegE,
    input  logic       RegWriteE,
    input  logic [4:0] write_reg_E,
    input  logic [4:0] rs_addr_D,
    input  logic [4:0] rt_addr_D,
    output logic       lu
);

    logic w_dest_real;
    logic w_dep;

    // $zero is hard-wired, so a load into it is never a true dependency
    assign w_dest_real = (write_reg_E != 5'd0);
    assign w_dep       = (write_reg_E == rs_addr_D) | (write_reg_E == rt_addr_D);
    assign lu          = MemtoRegE & RegWriteE & w_dest_real & w_dep;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/flush sequencer for the 5-stage pipeline: stalls, flushes, halt drain and run statistics.
//
// state     | meaning
// ST_RUN    | normal execution, hazard priority mux active
// ST_DRAIN  | halt seen in ID, bubbling EX/MEM/WB for DRAIN_CYCLES cycles
// ST_HALTED | pipeline empty, done asserted, counters frozen until reset
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned  DRAIN_CYCLES = 4,
    parameter logic [31:0]  HALT_WORD    = HALT_WORD_DEF,
    parameter int unsigned  CNT_W        = 32
)
(
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [31:0]      instr_D,
    input  logic [4:0]       rs_addr_D,
    input  logic [4:0]       rt_addr_D,
    input  logic             JumpD,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic [4:0]       write_reg_E,
    input  logic             branch_taken_E,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DCW-1:0]   r_drain_cnt;
    logic [DCW-1:0]   w_drain_nxt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_done;

    logic w_lu;
    logic w_halt;
    logic w_stall_inc;
    logic w_stall_f;
    logic w_stall_d;
    logic w_flush_d;
    logic w_flush_e;

    hazard_detect u_hazard_detect (
        .MemtoRegE   (MemtoRegE),
        .RegWriteE   (RegWriteE),
        .write_reg_E (write_reg_E),
        .rs_addr_D   (rs_addr_D),
        .rt_addr_D   (rt_addr_D),
        .lu          (w_lu)
    );

    assign w_halt = (instr_D == HALT_WORD);

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_stall_inc = 1'b0;
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        case (r_state)
            ST_RUN: begin
                // taken branch means instr_D is wrong-path, so its hazards and halt are irrelevant
                if (branch_taken_E) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (w_lu) begin
                    w_stall_f   = 1'b1;
                    w_stall_d   = 1'b1;
                    w_flush_e   = 1'b1;
                    w_stall_inc = 1'b1;
                end else if (w_halt) begin
                    w_stall_f   = 1'b1;
                    w_flush_d   = 1'b1;
                    w_flush_e   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = DCW'(1);
                end else if (JumpD) begin
                    w_flush_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_stall_f = 1'b1;
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
                if (r_drain_cnt == DCW'(DRAIN_CYCLES)) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_drain_nxt = r_drain_cnt + DCW'(1);
                end
            end
            ST_HALTED: begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_done      <= (w_state_nxt == ST_HALTED);
            if ((r_state != ST_HALTED) && (r_cycle_cnt != {CNT_W{1'b1}})) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // reset must silence the pipeline controls even before the state register settles
    assign StallF      = RST_n & w_stall_f;
    assign StallD      = RST_n & w_stall_d;
    assign FlushD      = RST_n & w_flush_d;
    assign FlushE      = RST_n & w_flush_e;
    assign done        = r_done;
    assign cycle_count = r_cycle_cnt;
    assign stall_count = r_stall_cnt;

endmodule
